mem_arbiter: RTL and testbench

Shares one backing memory port with request/ready/valid handshaking between the hart's instruction-fetch requester and data requester, for the multi-cycle memory phase. It sits between the hart and the memory model. The arbiter tracks one outstanding transaction at a time and routes each response back to the requester that issued it. Data accesses win by default. A bounded starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/arb_starve_cnt.sv | 42 ++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } owner_t;

    localparam logic [3:0] FETCH_MASK = 4'b1111;
    localparam int unsigned CNT_W     = 4;

    // Clears the byte-offset bits so the backing memory only sees word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch waits.
module arb_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, increment saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (i_inc && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_at_limit = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one backing memory port between fetch and data requesters,
// one outstanding transaction at a time, data-first with a fetch starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    state_t state_q;
    state_t state_d;
    owner_t owner_q;
    owner_t owner_d;

    logic   at_limit_s;
    logic   grant_s;
    owner_t sel_s;
    logic   present_s;
    logic   accept_s;
    logic   resp_s;
    logic   starve_inc_s;
    logic   starve_clr_s;

    // Grant selection: fresh arbitration only in IDLE, frozen owner in HOLD.
    always_comb begin
        grant_s = 1'b0;
        sel_s   = owner_q;
        case (state_q)
            IDLE: begin
                if (i_dmem_req && (!at_limit_s || !i_imem_req)) begin
                    grant_s = 1'b1;
                    sel_s   = DMEM;
                end else if (i_imem_req) begin
                    grant_s = 1'b1;
                    sel_s   = IMEM;
                end else begin
                    grant_s = 1'b0;
                    sel_s   = owner_q;
                end
            end
            HOLD: begin
                grant_s = 1'b1;
                sel_s   = owner_q;
            end
            default: begin
                grant_s = 1'b0;
                sel_s   = owner_q;
            end
        endcase
    end

    // Reset masks the request so nothing is presented or accepted while it is low.
    assign present_s = grant_s && i_rst_n;
    assign accept_s  = present_s && i_mem_ready;
    assign resp_s    = (state_q == WAIT) && i_mem_valid && i_rst_n;

    // Starvation bookkeeping: only a data accept with fetch still waiting counts up.
    assign starve_inc_s = accept_s && (sel_s == DMEM) && i_imem_req;
    assign starve_clr_s = accept_s && ((sel_s == IMEM) || !i_imem_req);

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (starve_inc_s),
        .i_clr      (starve_clr_s),
        .o_at_limit (at_limit_s)
    );

    // Next-state and owner capture for the IDLE/HOLD/WAIT transaction FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    owner_d = sel_s;
                    state_d = i_mem_ready ? WAIT : HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (i_mem_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = HOLD;
                end
            end
            WAIT: begin
                if (i_mem_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and owner registers; a reset mid-transaction abandons the response.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            owner_q <= IMEM;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Request mux toward memory, requester readys and response routing.
    always_comb begin
        o_mem_req    = present_s;
        o_mem_addr   = word_align(i_imem_addr);
        o_mem_wen    = 1'b0;
        o_mem_wdata  = 32'h0000_0000;
        o_mem_mask   = FETCH_MASK;
        o_imem_ready = 1'b0;
        o_dmem_ready = 1'b0;
        o_imem_valid = 1'b0;
        o_dmem_valid = 1'b0;
        o_imem_rdata = 32'h0000_0000;
        o_dmem_rdata = 32'h0000_0000;
        if (sel_s == DMEM) begin
            o_mem_addr   = word_align(i_dmem_addr);
            o_mem_wen    = present_s && i_dmem_wen;
            o_mem_wdata  = i_dmem_wdata;
            o_mem_mask   = i_dmem_mask;
            o_dmem_ready = accept_s;
        end else begin
            o_imem_ready = accept_s;
        end
        if (resp_s && (owner_q == DMEM)) begin
            o_dmem_valid = 1'b1;
            o_dmem_rdata = i_mem_rdata;
        end else if (resp_s) begin
            o_imem_valid = 1'b1;
            o_imem_rdata = i_mem_rdata;
        end else begin
            o_imem_valid = 1'b0;
            o_dmem_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requester stimulus plus a memory
// model; accept and response monitors pop expectations queued by the stimulus.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic        o_imem_ready;
    logic        o_imem_valid;
    logic [31:0] o_imem_rdata;
    logic        i_dmem_req;
    logic [31:0] i_dmem_addr;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic        o_dmem_ready;
    logic        o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    typedef struct {
        owner_t      own;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } acc_t;

    typedef struct {
        owner_t      own;
        logic        chk;
        logic [31:0] data;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    int          mem_lat  = 1;
    int          resp_cnt = 0;
    logic [31:0] resp_word = 32'h0;
    logic        spur = 1'b0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_imem_req   (i_imem_req),
        .i_imem_addr  (i_imem_addr),
        .o_imem_ready (o_imem_ready),
        .o_imem_valid (o_imem_valid),
        .o_imem_rdata (o_imem_rdata),
        .i_dmem_req   (i_dmem_req),
        .i_dmem_addr  (i_dmem_addr),
        .i_dmem_wen   (i_dmem_wen),
        .i_dmem_wdata (i_dmem_wdata),
        .i_dmem_mask  (i_dmem_mask),
        .o_dmem_ready (o_dmem_ready),
        .o_dmem_valid (o_dmem_valid),
        .o_dmem_rdata (o_dmem_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_ready  (i_mem_ready),
        .i_mem_valid  (i_mem_valid),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents used by the model; expectations below are written out by hand.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0104: return 32'h0000_0013;
            32'h0000_0108: return 32'h0010_0093;
            32'h0000_3000: return 32'hCAFE_F00D;
            default:       return {a[15:0], 16'h5A5A};
        endcase
    endfunction

    // Memory model: observes accepts at negedge, answers mem_lat cycles later.
    initial begin
        logic        acc;
        logic [31:0] a;
        i_mem_valid = 1'b0;
        i_mem_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            acc = o_mem_req && i_mem_ready && i_rst_n;
            a   = o_mem_addr;
            @(posedge i_clk);
            #1;
            i_mem_valid = spur;
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    i_mem_valid = 1'b1;
                    i_mem_rdata = resp_word;
                end
            end
            if (acc) begin
                resp_cnt  = mem_lat;
                resp_word = mem_word(a);
            end
        end
    end

    // Accept monitor: every handshake toward memory must match the next expectation.
    initial begin
        acc_t   e;
        owner_t got;
        logic   ok;
        forever begin
            @(negedge i_clk);
            if (o_mem_req && i_mem_ready) begin
                checks++;
                got = o_dmem_ready ? DMEM : IMEM;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected got own=%0d addr=%h", got, o_mem_addr);
                end else begin
                    e  = acc_q.pop_front();
                    ok = (o_imem_ready ^ o_dmem_ready) && (got == e.own) &&
                         (o_mem_addr == e.addr) && (o_mem_wen == e.wen) &&
                         (o_mem_mask == e.mask) && (!e.wen || (o_mem_wdata == e.wdata));
                    if (!ok) begin
                        errors++;
                        $display("FAIL accept got rdy=%b%b own=%0d addr=%h wen=%b mask=%b wdata=%h want own=%0d addr=%h wen=%b mask=%b wdata=%h",
                                 o_imem_ready, o_dmem_ready, got, o_mem_addr, o_mem_wen, o_mem_mask, o_mem_wdata,
                                 e.own, e.addr, e.wen, e.mask, e.wdata);
                    end
                end
            end
        end
    end

    // Response monitor: every valid pulse must match the next expected response.
    initial begin
        rsp_t        e;
        owner_t      got;
        logic [31:0] d;
        logic [31:0] other;
        logic        ok;
        forever begin
            @(negedge i_clk);
            if (o_imem_valid || o_dmem_valid) begin
                checks++;
                got   = o_dmem_valid ? DMEM : IMEM;
                d     = o_dmem_valid ? o_dmem_rdata : o_imem_rdata;
                other = o_dmem_valid ? o_imem_rdata : o_dmem_rdata;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got own=%0d data=%h", got, d);
                end else begin
                    e  = rsp_q.pop_front();
                    ok = (o_imem_valid ^ o_dmem_valid) && (got == e.own) &&
                         (other == 32'h0) && (!e.chk || (d == e.data));
                    if (!ok) begin
                        errors++;
                        $display("FAIL resp got valid=%b%b own=%0d data=%h want own=%0d data=%h",
                                 o_imem_valid, o_dmem_valid, got, d, e.own, e.data);
                    end
                end
            end
        end
    end

    task automatic exp_acc(input owner_t own, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] mask);
        acc_t e;
        e.own = own; e.addr = addr; e.wen = wen; e.wdata = wdata; e.mask = mask;
        acc_q.push_back(e);
    endtask

    task automatic exp_rsp(input owner_t own, input logic chk, input logic [31:0] data);
        rsp_t e;
        e.own = own; e.chk = chk; e.data = data;
        rsp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Fetch requester: hold req until accepted (bounded), then drop it.
    task automatic imem_xact(input logic [31:0] addr);
        bit seen = 1'b0;
        i_imem_addr = addr;
        i_imem_req  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (o_imem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL imem_timeout addr=%h got=no_ready want=ready", addr);
        end
        @(posedge i_clk);
        #1;
        i_imem_req = 1'b0;
    endtask

    // Data requester: hold req and fields until accepted (bounded), then drop req.
    task automatic dmem_xact(input logic wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask);
        bit seen = 1'b0;
        i_dmem_addr  = addr;
        i_dmem_wen   = wen;
        i_dmem_wdata = wdata;
        i_dmem_mask  = mask;
        i_dmem_req   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (o_dmem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL dmem_timeout addr=%h got=no_ready want=ready", addr);
        end
        @(posedge i_clk);
        #1;
        i_dmem_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_imem_req   = 1'b1;
        i_imem_addr  = 32'h0000_0200;
        i_dmem_req   = 1'b0;
        i_dmem_addr  = 32'h0;
        i_dmem_wen   = 1'b0;
        i_dmem_wdata = 32'h0;
        i_dmem_mask  = 4'b0000;
        i_mem_ready  = 1'b1;

        // Reset: request present but everything toward memory and requesters quiet.
        idle_cycles(2);
        @(negedge i_clk);
        check("rst_mem_req", {31'h0, o_mem_req}, 32'h0);
        check("rst_readys", {30'h0, o_imem_ready, o_dmem_ready}, 32'h0);
        check("rst_valids", {30'h0, o_imem_valid, o_dmem_valid}, 32'h0);
        check("rst_wen", {31'h0, o_mem_wen}, 32'h0);
        check("rst_state", {30'h0, dut.state_q}, {30'h0, IDLE});
        check("rst_owner", {31'h0, dut.owner_q}, {31'h0, IMEM});
        @(posedge i_clk);
        #1;
        i_imem_req = 1'b0;
        i_rst_n    = 1'b1;
        idle_cycles(1);

        // Fetch only, 0x104 -> 0x13.
        mem_lat = 1;
        exp_acc(IMEM, 32'h0000_0104, 1'b0, 32'h0, 4'b1111);
        exp_rsp(IMEM, 1'b1, 32'h0000_0013);
        imem_xact(32'h0000_0104);
        idle_cycles(4);

        // Simultaneous: store to 0x2003 goes first, word aligned; fetch follows.
        exp_acc(DMEM, 32'h0000_2000, 1'b1, 32'h1100_0000, 4'b1000);
        exp_acc(IMEM, 32'h0000_0108, 1'b0, 32'h0, 4'b1111);
        exp_rsp(DMEM, 1'b0, 32'h0);
        exp_rsp(IMEM, 1'b1, 32'h0010_0093);
        fork
            imem_xact(32'h0000_0108);
            dmem_xact(1'b1, 32'h0000_2003, 32'h1100_0000, 4'b1000);
        join
        idle_cycles(4);

        // Stalled memory: fetch sits in HOLD, a data request arriving meanwhile waits.
        i_mem_ready = 1'b0;
        exp_acc(IMEM, 32'h0000_010C, 1'b0, 32'h0, 4'b1111);
        exp_acc(DMEM, 32'h0000_3000, 1'b0, 32'h0, 4'b1111);
        exp_rsp(IMEM, 1'b1, 32'h010C_5A5A);
        exp_rsp(DMEM, 1'b1, 32'hCAFE_F00D);
        fork
            imem_xact(32'h0000_010C);
            begin
                idle_cycles(1);
                dmem_xact(1'b0, 32'h0000_3000, 32'h0, 4'b1111);
            end
            begin
                idle_cycles(1);
                @(negedge i_clk);
                check("hold_state", {30'h0, dut.state_q}, {30'h0, HOLD});
                check("hold_owner", {31'h0, dut.owner_q}, {31'h0, IMEM});
                idle_cycles(2);
                i_mem_ready = 1'b1;
            end
        join
        idle_cycles(4);

        // Starvation guard: four data accepts, then the waiting fetch, then data again.
        exp_acc(DMEM, 32'h0000_4000, 1'b0, 32'h0, 4'b1111);
        exp_acc(DMEM, 32'h0000_4004, 1'b0, 32'h0, 4'b1111);
        exp_acc(DMEM, 32'h0000_4008, 1'b0, 32'h0, 4'b1111);
        exp_acc(DMEM, 32'h0000_400C, 1'b0, 32'h0, 4'b1111);
        exp_acc(IMEM, 32'h0000_0110, 1'b0, 32'h0, 4'b1111);
        exp_acc(DMEM, 32'h0000_4010, 1'b0, 32'h0, 4'b1111);
        exp_acc(DMEM, 32'h0000_4014, 1'b0, 32'h0, 4'b1111);
        exp_rsp(DMEM, 1'b1, 32'h4000_5A5A);
        exp_rsp(DMEM, 1'b1, 32'h4004_5A5A);
        exp_rsp(DMEM, 1'b1, 32'h4008_5A5A);
        exp_rsp(DMEM, 1'b1, 32'h400C_5A5A);
        exp_rsp(IMEM, 1'b1, 32'h0110_5A5A);
        exp_rsp(DMEM, 1'b1, 32'h4010_5A5A);
        exp_rsp(DMEM, 1'b1, 32'h4014_5A5A);
        fork
            begin
                imem_xact(32'h0000_0110);
                check("starve_cnt_after_fetch", {28'h0, dut.u_starve.cnt_q}, 32'h0);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    dmem_xact(1'b0, 32'h0000_4000 + 32'(4 * k), 32'h0, 4'b1111);
                end
            end
        join
        idle_cycles(4);

        // Reset during WAIT: the late response must not be forwarded.
        mem_lat = 3;
        exp_acc(IMEM, 32'h0000_0114, 1'b0, 32'h0, 4'b1111);
        imem_xact(32'h0000_0114);
        check("wait_state", {30'h0, dut.state_q}, {30'h0, WAIT});
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("rst_wait_valids", {30'h0, o_imem_valid, o_dmem_valid}, 32'h0);
        @(posedge i_clk);
        #1;
        check("rst_wait_state", {30'h0, dut.state_q}, {30'h0, IDLE});
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            if (i_mem_valid) begin
                check("late_valid_dropped", {30'h0, o_imem_valid, o_dmem_valid}, 32'h0);
            end
        end
        check("after_late_state", {30'h0, dut.state_q}, {30'h0, IDLE});
        @(posedge i_clk);
        #1;
        mem_lat = 1;
        exp_acc(IMEM, 32'h0000_0118, 1'b0, 32'h0, 4'b1111);
        exp_rsp(IMEM, 1'b1, 32'h0118_5A5A);
        imem_xact(32'h0000_0118);
        idle_cycles(4);

        // Spurious memory valid while IDLE.
        @(negedge i_clk);
        spur = 1'b1;
        @(negedge i_clk);
        check("spur_valid_seen", {31'h0, i_mem_valid}, 32'h1);
        check("spur_no_fwd", {30'h0, o_imem_valid, o_dmem_valid}, 32'h0);
        spur = 1'b0;
        @(negedge i_clk);
        check("spur_state", {30'h0, dut.state_q}, {30'h0, IDLE});
        idle_cycles(4);

        check("acc_q_drained", 32'(acc_q.size()), 32'h0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
